sequenciador_notas: RTL

SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

---
 rtl/sequenciador_notas_pkg.sv | 25 ++
 rtl/sequenciador_notas_contador.sv | 27 ++
 rtl/sequenciador_notas.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sequenciador_notas_pkg.sv
// Shared note codes and FSM encodings for the note sequencer and the buzzer.
// Latency: n/a (definitions only). Backpressure: n/a.
package sequenciador_notas_pkg;

    localparam logic [3:0] NOTA_SILENCIO = 4'b0000;
    localparam logic [3:0] NOTA_SOL      = 4'b0001;
    localparam logic [3:0] NOTA_LA       = 4'b0010;
    localparam logic [3:0] NOTA_SI       = 4'b0100;
    localparam logic [3:0] NOTA_DO       = 4'b1000;

    localparam int         NUM_SLOTS = 16;
    localparam logic [4:0] TAM_MAX   = 5'd16;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        TOCA   = 2'd1,
        PAUSA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    function automatic logic eh_one_hot(input logic [3:0] n);
        return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sequenciador_notas_contador.sv
// Duration counter: counts while enabled, flags the cycle it reaches limite.
// Latency: fim is combinational on the current count. Backpressure: none.
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] valor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valor <= '0;
        else if (zera_s)
            valor <= '0;
        else if (conta)
            valor <= valor + 1'b1;
    end

    assign fim = conta && (valor == limite);

endmodule

// File: rtl/sequenciador_notas.sv
// Plays up to 16 stored one-hot notes with fixed note/pause durations.
// Latency: first note one cycle after iniciar. Backpressure: none; parar aborts.
module sequenciador_notas
    import sequenciador_notas_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int DUR_NOTA_MS  = 500,
    parameter int DUR_PAUSA_MS = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       escrever,
    input  logic [3:0] endereco,
    input  logic [3:0] nota_in,
    input  logic [4:0] tamanho,
    output logic [3:0] seletor,
    output logic       conta,
    output logic       tocando,
    output logic       fim
);

    localparam int DN   = CLOCK_FREQ / 1000 * DUR_NOTA_MS;
    localparam int DP   = CLOCK_FREQ / 1000 * DUR_PAUSA_MS;
    localparam int DMAX = (DN > DP) ? DN : DP;
    localparam int TW   = $clog2(DMAX + 1);

    localparam logic [TW-1:0] LIM_NOTA   = TW'(DN - 1);
    localparam logic [TW-1:0] LIM_PAUSA  = TW'((DP > 0) ? DP - 1 : 0);
    localparam logic          SEM_PAUSA  = (DP == 0);

    estado_t       estado, prox;
    logic [3:0]    mem [NUM_SLOTS];
    logic [3:0]    indice;
    logic [4:0]    tam;
    logic [4:0]    tam_pedido;
    logic [3:0]    nota_atual;
    logic          ultimo;
    logic          avanca;
    logic          fim_t;
    logic          conta_t;
    logic          zera_t;
    logic [TW-1:0] limite;

    assign tam_pedido = (tamanho > TAM_MAX) ? TAM_MAX : tamanho;
    assign nota_atual = mem[indice];
    assign ultimo     = ({1'b0, indice} == (tam - 5'd1));

    // Timer is held at zero outside timed states so every TOCA/PAUSA entry starts at 0.
    assign conta_t = (estado == TOCA) || (estado == PAUSA);
    assign zera_t  = !conta_t || fim_t || parar;
    assign limite  = (estado == PAUSA) ? LIM_PAUSA : LIM_NOTA;

    contador_m #(.W(TW)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zera_t),
        .conta  (conta_t),
        .limite (limite),
        .fim    (fim_t)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                mem[i] <= NOTA_SILENCIO;
        end else if (estado == OCIOSO && escrever) begin
            mem[endereco] <= nota_in;
        end
    end

    assign avanca = !parar && fim_t &&
                    ((estado == PAUSA) || (estado == TOCA && !ultimo && SEM_PAUSA));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            indice <= 4'd0;
            tam    <= 5'd0;
        end else if (estado == OCIOSO) begin
            indice <= 4'd0;
            if (iniciar)
                tam <= tam_pedido;
        end else if (avanca) begin
            indice <= indice + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar)
                    prox = (tam_pedido == 5'd0) ? FIM : TOCA;
            end
            TOCA: begin
                if (parar)
                    prox = OCIOSO;
                else if (fim_t) begin
                    if (ultimo)
                        prox = FIM;
                    else if (!SEM_PAUSA)
                        prox = PAUSA;
                    else
                        prox = TOCA;
                end
            end
            PAUSA: begin
                if (parar)
                    prox = OCIOSO;
                else if (fim_t)
                    prox = TOCA;
            end
            FIM:     prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_comb begin
        seletor = NOTA_SILENCIO;
        conta   = 1'b0;
        tocando = (estado != OCIOSO);
        fim     = 1'b0;
        case (estado)
            TOCA: begin
                if (eh_one_hot(nota_atual)) begin
                    seletor = nota_atual;
                    conta   = 1'b1;
                end
            end
            FIM:     fim = 1'b1;
            default: ;
        endcase
    end

endmodule
